// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared 640x480 timing constants and framebuffer grant encoding
// Purpose : constants shared by the framebuffer arbiter and its writer FIFO.
// Contents: HBP/VBP first active hc/vc, ACT_W/ACT_H active area, HPIXELS/VLINES
//           full raster, ADDR_W framebuffer address width, FIFO_AW writer FIFO
//           depth exponent, grant_t RAM port owner encoding.
package vga_pkg;
   localparam int HBP     = 144;
   localparam int VBP     = 31;
   localparam int ACT_W   = 640;
   localparam int ACT_H   = 480;
   localparam int HPIXELS = 800;
   localparam int VLINES  = 521;
   localparam int ADDR_W  = 19;
   localparam int FIFO_AW = 4;

   typedef enum logic [1:0] {
      G_NONE = 2'd0,
      G_DISP = 2'd1,
      G_WR   = 2'd2
   } grant_t;
endpackage

// File: rtl/fb_wr_fifo.sv
// rtl/fb_wr_fifo.sv - synchronous FIFO buffering {addr,data} writer requests
// Purpose : holds scope-writer requests until the arbiter finds an idle RAM slot.
// Ports   : dclk clock; clr_n async active-low reset; push/din write side;
//           pop/dout read side (dout is the current head, valid while !empty);
//           full/empty occupancy flags derived from the entry count.
// Push while full and pop while empty are ignored.
module fb_wr_fifo #(
   parameter int AW = 4,
   parameter int DW = 27
) (
   input  logic          dclk,
   input  logic          clr_n,
   input  logic          push,
   input  logic [DW-1:0] din,
   input  logic          pop,
   output logic [DW-1:0] dout,
   output logic          full,
   output logic          empty
);
   localparam int DEPTH = 1 << AW;
   localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0]   CNT_FULL = {1'b1, {AW{1'b0}}};

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic [AW:0]   count;
   logic          push_ok, pop_ok;

   assign full    = (count == CNT_FULL);
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign dout    = mem[rp];

   always_ff @(posedge dclk or negedge clr_n) begin
      if (!clr_n) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (push_ok) wp <= wp + PTR_ONE;
         if (pop_ok)  rp <= rp + PTR_ONE;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: ;
         endcase
      end
   end

   always_ff @(posedge dclk) begin
      if (push_ok) mem[wp] <= din;
   end
endmodule

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - single-port framebuffer arbiter, display fetch over scope writer
// Purpose : shares one 1-cycle-latency single-port RAM between VGA pixel fetch
//           (strict priority) and a FIFO-buffered sample writer drained in idle slots.
// Ports   : dclk clock; clr_n async active-low reset; hc/vc raster counters;
//           wr_valid/wr_ready/wr_addr/wr_data writer request; ram_en/ram_we/
//           ram_addr/ram_wdata/ram_rdata RAM port; color pixel index (0 when blank).
// Option  : FB_ARB_STATS_EN adds stall_cnt, saturating count of cycles the writer
//           was held off by a full FIFO, cleared every frame.
module vga_fb_arbiter
   import vga_pkg::*;
(
   input  logic              dclk,
   input  logic              clr_n,
   input  logic [9:0]        hc,
   input  logic [9:0]        vc,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [7:0]        wr_data,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [7:0]        ram_wdata,
   input  logic [7:0]        ram_rdata,
`ifdef FB_ARB_STATS_EN
   output logic [15:0]       stall_cnt,
`endif
   output logic [7:0]        color
);
   localparam int ENTRY_W = ADDR_W + 8;
   localparam logic [9:0] H_LO = 10'(HBP - 1);
   localparam logic [9:0] H_HI = 10'(HBP + ACT_W - 1);
   localparam logic [9:0] V_LO = 10'(VBP);
   localparam logic [9:0] V_HI = 10'(VBP + ACT_H);
   localparam logic [ADDR_W-1:0] FB_SIZE = ADDR_W'(ACT_W * ACT_H);

   logic               frame_start, fetch, run_q;
   grant_t             grant, grant_q;
   logic [ADDR_W-1:0]  disp_addr;
   logic               fifo_full, fifo_empty, push, pop;
   logic [ENTRY_W-1:0] head;
   logic [ADDR_W-1:0]  head_addr;
   logic [7:0]         head_data;

   assign frame_start = (vc == '0) && (hc == '0);
   // run_q holds off fetch after reset until a clean frame start, so
   // disp_addr always lines up with the raster.
   assign fetch = run_q && (vc >= V_LO) && (vc < V_HI) && (hc >= H_LO) && (hc < H_HI);

   assign wr_ready  = !fifo_full;
   assign push      = wr_valid && wr_ready;
   assign pop       = (grant == G_WR);
   assign head_addr = head[ENTRY_W-1:8];
   assign head_data = head[7:0];

   fb_wr_fifo #(.AW(FIFO_AW), .DW(ENTRY_W)) u_fifo (
      .dclk  (dclk),
      .clr_n (clr_n),
      .push  (push),
      .din   ({wr_addr, wr_data}),
      .pop   (pop),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // The slot owner is decided in the same cycle so the RAM sees the access
   // one cycle before the pixel is shown; grant_q records what was issued.
   always_comb begin
      grant = G_NONE;
      if (fetch)            grant = G_DISP;
      else if (!fifo_empty) grant = G_WR;
   end

   always_comb begin
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      case (grant)
         G_DISP: begin
            ram_en   = 1'b1;
            ram_addr = disp_addr;
         end
         G_WR: begin
            // Off-screen writes still drain from the FIFO but never reach the RAM.
            if (head_addr < FB_SIZE) begin
               ram_en    = 1'b1;
               ram_we    = 1'b1;
               ram_addr  = head_addr;
               ram_wdata = head_data;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge dclk or negedge clr_n) begin
      if (!clr_n) begin
         run_q     <= 1'b0;
         grant_q   <= G_NONE;
         disp_addr <= '0;
      end else begin
         grant_q <= grant;
         if (frame_start) begin
            run_q     <= 1'b1;
            disp_addr <= '0;
         end else if (grant == G_DISP) begin
            disp_addr <= disp_addr + ADDR_W'(1);
         end
      end
   end

   assign color = (grant_q == G_DISP) ? ram_rdata : 8'h00;

`ifdef FB_ARB_STATS_EN
   always_ff @(posedge dclk or negedge clr_n) begin
      if (!clr_n) begin
         stall_cnt <= '0;
      end else if (frame_start) begin
         stall_cnt <= '0;
      end else if (wr_valid && !wr_ready && (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif
endmodule
